// File: rtl/riscv_bus_arbiter.sv
// Round-robin arbiter merging NUM_MASTERS request ports onto one memory port, with a
// single outstanding transaction and a response timeout that completes with an error.
module riscv_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*3-1:0]          m_format,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic                              m_error,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              s_req,
    output logic                              s_write,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [2:0]                        s_format,
    input  logic                              s_ready,
    input  logic                              s_rvalid,
    input  logic [DATA_WIDTH-1:0]             s_rdata
);
    localparam int unsigned IdxW = $clog2(NUM_MASTERS);
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         last_q, last_d, owner_q, owner_d, winner, cand;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    found, grant, accept, resp, expired, timeout;
    logic [NUM_MASTERS-1:0]  m_ack_q, m_ack_d, m_done_q, m_done_d;
    logic                    m_error_q, m_error_d, s_req_q, s_req_d, s_write_q, s_write_d;
    logic [DATA_WIDTH-1:0]   m_rdata_q, m_rdata_d, s_wdata_q, s_wdata_d;
    logic [ADDR_WIDTH-1:0]   s_addr_q, s_addr_d;
    logic [2:0]              s_format_q, s_format_d;

    // First requester after the previous winner, wrapping around.
    always_comb begin
        winner = last_q;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = IdxW'((32'(last_q) + k) % NUM_MASTERS);
            if (!found && m_req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant   = (state_q == StIdle) && found;
    assign accept  = (state_q == StIssue) && s_req_q && s_ready;
    assign resp    = (state_q == StWaitResp) && s_rvalid;
    assign expired = (cnt_q == CntW'(TIMEOUT - 1));
    assign timeout = ((state_q == StIssue) || (state_q == StWaitResp)) && expired
                     && !accept && !resp;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            last_q     <= IdxW'(NUM_MASTERS - 1);
            owner_q    <= '0;
            cnt_q      <= '0;
            m_ack_q    <= '0;
            m_done_q   <= '0;
            m_error_q  <= 1'b0;
            m_rdata_q  <= '0;
            s_req_q    <= 1'b0;
            s_write_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_format_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            m_ack_q    <= m_ack_d;
            m_done_q   <= m_done_d;
            m_error_q  <= m_error_d;
            m_rdata_q  <= m_rdata_d;
            s_req_q    <= s_req_d;
            s_write_q  <= s_write_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_format_q <= s_format_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (grant) state_d = StIssue;
            StIssue: begin
                if (accept)       state_d = s_write_q ? StDone : StWaitResp;
                else if (expired) state_d = StIdle;
            end
            StWaitResp: begin
                if (resp)         state_d = StDone;
                else if (expired) state_d = StIdle;
            end
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d     = last_q;
        owner_d    = owner_q;
        s_write_d  = s_write_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_format_d = s_format_q;
        m_ack_d    = '0;
        if (grant) begin
            m_ack_d[winner] = 1'b1;
            last_d          = winner;
            owner_d         = winner;
            s_write_d       = m_write[winner];
            s_addr_d        = m_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            s_wdata_d       = m_wdata[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
            s_format_d      = m_format[32'(winner)*3 +: 3];
        end
        // First ISSUE cycle is the ack cycle; s_req follows from the next one.
        s_req_d = (state_q == StIssue) && (state_d == StIssue);
        cnt_d   = '0;
        if (((state_q == StIssue) || (state_q == StWaitResp)) && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
        m_done_d  = '0;
        m_error_d = timeout;
        if ((accept && s_write_q) || resp || timeout) m_done_d[owner_q] = 1'b1;
        m_rdata_d = m_rdata_q;
        if (resp)         m_rdata_d = s_rdata;
        else if (timeout) m_rdata_d = '0;
    end

    assign m_ack    = m_ack_q;
    assign m_done   = m_done_q;
    assign m_error  = m_error_q;
    assign m_rdata  = m_rdata_q;
    assign s_req    = s_req_q;
    assign s_write  = s_write_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_format = s_format_q;

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Bench for riscv_bus_arbiter: transaction-level timeline model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_riscv_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    m_req, m_write, m_ack, m_done;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*3-1:0]  m_format;
    logic            m_error, s_req, s_write, s_ready, s_rvalid;
    logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
    logic [AW-1:0]   s_addr;
    logic [2:0]      s_format;

    always #5 clock = ~clock;

    riscv_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .m_req(m_req), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_format(m_format), .m_ack(m_ack), .m_done(m_done),
        .m_error(m_error), .m_rdata(m_rdata), .s_req(s_req), .s_write(s_write),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_format(s_format), .s_ready(s_ready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    // Pending master requests and model expectations
    logic          pend [N];
    logic          pw   [N];
    logic [AW-1:0] pa   [N];
    logic [DW-1:0] pd   [N];
    logic [2:0]    pf   [N];
    int            last_grant;
    logic [N-1:0]  cur_mask;
    int            cur_pct;
    logic          stray_en;
    logic [N-1:0]  exp_ack, exp_done;
    logic          exp_err, exp_sreq, exp_zero, exp_write;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;
    logic [2:0]    exp_fmt;
    logic          chk_en = 1'b0;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    // DUT-side observations for literal checks
    int            mon_ack_cyc, mon_done_cyc, mon_sreq_cyc, mon_sreq_end, mon_sreq_run;
    logic [N-1:0]  mon_ack_val, mon_done_val;
    logic [AW-1:0] mon_saddr;
    logic          sreq_prev = 1'b0;
    int            dut_grants [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, want);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("m_ack", 32'(m_ack), 32'(exp_ack));
            check("m_done", 32'(m_done), 32'(exp_done));
            check("s_req", 32'(s_req), 32'(exp_sreq));
            check("m_rdata", m_rdata, exp_rdata);
            if (exp_done != '0) check("m_error", 32'(m_error), 32'(exp_err));
            if (exp_sreq) begin
                check("s_write", 32'(s_write), 32'(exp_write));
                check("s_addr", s_addr, exp_addr);
                check("s_wdata", s_wdata, exp_wdata);
                check("s_format", 32'(s_format), 32'(exp_fmt));
            end
            if (exp_zero) begin
                check("rst_m_error", 32'(m_error), 32'd0);
                check("rst_s_write", 32'(s_write), 32'd0);
                check("rst_s_addr", s_addr, 32'd0);
                check("rst_s_wdata", s_wdata, 32'd0);
                check("rst_s_format", 32'(s_format), 32'd0);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (m_ack != '0) begin
                mon_ack_cyc = cyc;
                mon_ack_val = m_ack;
                for (int i = 0; i < N; i++) if (m_ack[i]) dut_grants.push_back(i);
            end
            if (m_done != '0) begin
                mon_done_cyc = cyc;
                mon_done_val = m_done;
            end
            if (s_req) begin
                if (!sreq_prev) begin
                    mon_sreq_cyc = cyc;
                    mon_saddr    = s_addr;
                    mon_sreq_run = 1;
                end else begin
                    mon_sreq_run++;
                end
                mon_sreq_end = cyc;
            end
            sreq_prev = s_req;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_quiet();
        exp_ack  = '0;
        exp_done = '0;
        exp_err  = 1'b0;
        exp_sreq = 1'b0;
        exp_zero = 1'b0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            m_req[i]              = pend[i];
            m_write[i]            = pw[i];
            m_addr[i*AW +: AW]    = pa[i];
            m_wdata[i*DW +: DW]   = pd[i];
            m_format[i*3 +: 3]    = pf[i];
        end
    endtask

    task automatic new_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [2:0] f);
        pend[i] = 1'b1;
        pw[i]   = w;
        pa[i]   = a;
        pd[i]   = d;
        pf[i]   = f;
    endtask

    task automatic maybe_add();
        for (int i = 0; i < N; i++) begin
            if (cur_mask[i] && !pend[i] && ($urandom_range(99) < cur_pct)) begin
                new_req(i, 1'($urandom_range(1)), $urandom, $urandom, 3'($urandom_range(7)));
            end
        end
    endtask

    task automatic stray();
        s_rvalid = stray_en ? 1'($urandom_range(1)) : 1'b0;
        s_rdata  = $urandom;
    endtask

    function automatic logic any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Round robin: first pending master after the previous winner
    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_grant + k) % N;
            if (pend[c]) return c;
        end
        return 0;
    endfunction

    task automatic cycle_inputs();
        s_ready = 1'b0;
        maybe_add();
        drive_reqs();
        stray();
    endtask

    task automatic idle_cycle();
        step();
        set_quiet();
        cycle_inputs();
    endtask

    // Called in an idle cycle with m_req driven. d = ready-low cycles after s_req rises,
    // r = WAIT cycles before rvalid, abort_j = WAIT cycle in which reset is pulled (-1 none).
    // Returns in an idle-state cycle whose expectations are already set.
    task automatic run_txn(input int d, input int r, input logic [DW-1:0] rd,
                           input int abort_j);
        int           w;
        logic [N-1:0] oh;
        logic         ok;
        w  = pick();
        oh = '0;
        oh[w] = 1'b1;
        step();
        set_quiet();
        exp_ack    = oh;
        exp_write  = pw[w];
        exp_addr   = pa[w];
        exp_wdata  = pd[w];
        exp_fmt    = pf[w];
        last_grant = w;
        pend[w]    = 1'b0;
        cycle_inputs();
        ok = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
            set_quiet();
            exp_sreq = 1'b1;
            cycle_inputs();
            if (k == d + 1) begin
                s_ready = 1'b1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            step();
            set_quiet();
            exp_done  = oh;
            exp_err   = 1'b1;
            exp_rdata = '0;
            cycle_inputs();
            return;
        end
        if (exp_write) begin
            step();
            set_quiet();
            exp_done = oh;
            cycle_inputs();
            idle_cycle();
            return;
        end
        ok = 1'b0;
        for (int j = 0; j < TO; j++) begin
            step();
            set_quiet();
            cycle_inputs();
            s_rvalid = 1'b0;
            if (j == abort_j) begin
                reset = 1'b0;
                step();
                set_quiet();
                exp_zero   = 1'b1;
                exp_rdata  = '0;
                reset      = 1'b1;
                last_grant = N - 1;
                cycle_inputs();
                return;
            end
            if (j == r) begin
                s_rvalid = 1'b1;
                s_rdata  = rd;
                ok = 1'b1;
                break;
            end
        end
        step();
        set_quiet();
        exp_done = oh;
        cycle_inputs();
        if (ok) begin
            exp_rdata = rd;
            idle_cycle();
        end else begin
            exp_err   = 1'b1;
            exp_rdata = '0;
        end
    endtask

    task automatic drain();
        cur_pct = 0;
        for (int g = 0; g < 2 * N && any_pend(); g++) run_txn(0, 0, $urandom, -1);
    endtask

    int exp_order2 [6] = '{0, 1, 0, 1, 0, 1};
    int exp_order6 [4] = '{1, 3, 1, 3};

    initial begin
        int d;
        int r;
        reset = 1'b0;
        for (int i = 0; i < N; i++) new_req(i, 1'b0, '0, '0, '0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_reqs();
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        last_grant = N - 1;
        cur_mask = '0; cur_pct = 0; stray_en = 1'b0;
        set_quiet();
        exp_zero = 1'b1; exp_rdata = '0;
        exp_write = 1'b0; exp_addr = '0; exp_wdata = '0; exp_fmt = '0;
        step();
        chk_en = 1'b1;
        step();
        check("reset_s_req", 32'(s_req), 32'd0);
        check("reset_m_ack", 32'(m_ack), 32'd0);
        reset = 1'b1;
        idle_cycle();

        // 1: master1 read 0x100, immediate ready, rvalid next cycle
        new_req(1, 1'b0, 32'h100, 32'h0, 3'b010);
        drive_reqs();
        run_txn(0, 0, 32'hDEADBEEF, -1);
        check("t1_ack_val", 32'(mon_ack_val), 32'h2);
        check("t1_sreq_lat", 32'(mon_sreq_cyc - mon_ack_cyc), 32'd1);
        check("t1_saddr", mon_saddr, 32'h100);
        check("t1_done_lat", 32'(mon_done_cyc - mon_ack_cyc), 32'd3);
        check("t1_done_val", 32'(mon_done_val), 32'h2);
        check("t1_rdata", m_rdata, 32'hDEADBEEF);

        // 2: masters 0 and 1 requesting continuously
        cur_mask = 4'b0011; cur_pct = 100;
        new_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        new_req(1, 1'b1, 32'h20, 32'h1, 3'b010);
        drive_reqs();
        dut_grants.delete();
        for (int t = 0; t < 6; t++) run_txn(0, 0, $urandom, -1);
        check("t2_count", 32'(dut_grants.size()), 32'd6);
        for (int t = 0; t < 6 && t < dut_grants.size(); t++)
            check("t2_order", 32'(dut_grants[t]), 32'(exp_order2[t]));
        drain();

        // 3: master0 write with s_ready low for 5 cycles
        new_req(0, 1'b1, 32'h200, 32'h55, 3'b010);
        drive_reqs();
        run_txn(5, 0, '0, -1);
        check("t3_sreq_run", 32'(mon_sreq_run), 32'd6);
        check("t3_saddr", mon_saddr, 32'h200);
        check("t3_done_after_accept", 32'(mon_done_cyc - mon_sreq_end), 32'd1);
        check("t3_done_val", 32'(mon_done_val), 32'h1);

        // 5: reset while waiting for read data, then master0 must win
        new_req(1, 1'b0, 32'h300, 32'h0, 3'b010);
        drive_reqs();
        run_txn(0, 10, '0, 3);
        check("t5_rst_rdata", m_rdata, 32'd0);
        check("t5_rst_done", 32'(m_done), 32'd0);
        new_req(0, 1'b0, 32'h400, 32'h0, 3'b010);
        new_req(1, 1'b0, 32'h500, 32'h0, 3'b010);
        drive_reqs();
        run_txn(0, 0, 32'h1234_5678, -1);
        check("t5_first_winner", 32'(mon_ack_val), 32'h1);

        // 6: masters 1 and 3 requesting
        cur_mask = 4'b1010; cur_pct = 100;
        new_req(3, 1'b1, 32'h600, 32'h7, 3'b001);
        drive_reqs();
        dut_grants.delete();
        for (int t = 0; t < 4; t++) run_txn(0, 0, $urandom, -1);
        for (int t = 0; t < 4 && t < dut_grants.size(); t++)
            check("t6_order", 32'(dut_grants[t]), 32'(exp_order6[t]));
        drain();

        // 4: read with no response times out; late rvalid ignored
        new_req(1, 1'b0, 32'h700, 32'h0, 3'b010);
        drive_reqs();
        run_txn(0, TO + 5, '0, -1);
        check("t4_done_val", 32'(m_done), 32'h2);
        check("t4_error", 32'(m_error), 32'd1);
        check("t4_rdata", m_rdata, 32'd0);
        check("t4_timeout_lat", 32'(cyc - mon_ack_cyc), 32'(TO + 2));
        s_rvalid = 1'b1;
        s_rdata  = 32'hFFFF_FFFF;
        for (int t = 0; t < 4; t++) begin
            step();
            set_quiet();
            s_rvalid = 1'b1;
            s_rdata  = 32'hFFFF_FFFF;
        end
        check("t4_stray_rdata", m_rdata, 32'd0);
        s_rvalid = 1'b0;

        // Randomized traffic
        cur_mask = '1; cur_pct = 30; stray_en = 1'b1;
        for (int it = 0; it < 300; it++) begin
            if (any_pend()) begin
                d = ($urandom_range(9) == 0) ? int'($urandom_range(TO + 1))
                                             : int'($urandom_range(3));
                r = ($urandom_range(9) == 0) ? int'($urandom_range(TO + 1))
                                             : int'($urandom_range(3));
                run_txn(d, r, $urandom, -1);
            end else begin
                idle_cycle();
            end
        end
        stray_en = 1'b0;
        drain();
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
